jt10_adpcm_rom_arb: RTL and testbench

- Shares one external sample-memory port (SDRAM/BRAM controller) between the ADPCM-A fetch path and the ADPCM-B fetch path of the YM2610 core.
- Each requester gets a one-entry read cache (tag + data) and a ready flag.
- A round-robin FSM issues misses to memory over a level req/ack handshake.
- Sits between the ADPCM drivers' addr/roe_n outputs and the board memory controller.

---
 rtl/jt10_adpcm_arb_pkg.sv | 13 +
 rtl/jt10_adpcm_rom_slot.sv | 50 +++++
 rtl/jt10_adpcm_rom_arb.sv | 125 ++++++++++++
 tb/tb_jt10_adpcm_rom_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt10_adpcm_arb_pkg.sv
// Shared definitions for the ADPCM sample-ROM arbiter: FSM encoding and requester ids.
package jt10_adpcm_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWaitA = 2'd1,
        StWaitB = 2'd2
    } arb_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/jt10_adpcm_rom_slot.sv
// One-entry read cache for a single ADPCM requester: tag/data/valid plus hit and miss flags.
module jt10_adpcm_rom_slot #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_i,
    input  logic          roe_n_i,
    input  logic          fill_en_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_data_i,
    output logic [DW-1:0] data_o,
    output logic          hit_o,
    output logic          miss_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en_i) begin
            valid_d = 1'b1;
            tag_d   = fill_addr_i;
            data_d  = fill_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // The hit flag ignores roe_n so the driver can see cached data while idle.
    assign hit_o  = valid_q && (tag_q == addr_i);
    assign miss_o = !roe_n_i && !hit_o;
    assign data_o = data_q;

endmodule

// File: rtl/jt10_adpcm_rom_arb.sv
// Round-robin arbiter sharing one sample-memory port between the ADPCM-A and ADPCM-B fetch paths.
module jt10_adpcm_rom_arb
    import jt10_adpcm_arb_pkg::*;
#(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a_addr,
    input  logic          a_roe_n,
    output logic [DW-1:0] a_data,
    output logic          a_ok,
    input  logic [AW-1:0] b_addr,
    input  logic          b_roe_n,
    output logic [DW-1:0] b_data,
    output logic          b_ok,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data
);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic miss_a, miss_b, hit_a, hit_b;
    logic fill_a, fill_b;

    jt10_adpcm_rom_slot #(
        .AW (AW),
        .DW (DW)
    ) u_slot_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (a_addr),
        .roe_n_i     (a_roe_n),
        .fill_en_i   (fill_a),
        .fill_addr_i (mem_addr_q),
        .fill_data_i (mem_data),
        .data_o      (a_data),
        .hit_o       (hit_a),
        .miss_o      (miss_a)
    );

    jt10_adpcm_rom_slot #(
        .AW (AW),
        .DW (DW)
    ) u_slot_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (b_addr),
        .roe_n_i     (b_roe_n),
        .fill_en_i   (fill_b),
        .fill_addr_i (mem_addr_q),
        .fill_data_i (mem_data),
        .data_o      (b_data),
        .hit_o       (hit_b),
        .miss_o      (miss_b)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fill_a     = 1'b0;
        fill_b     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss_a || miss_b) begin
                    // On a tie, the requester not served last wins.
                    if (miss_a && miss_b) begin
                        last_d = (last_q == REQ_B) ? REQ_A : REQ_B;
                    end else begin
                        last_d = miss_a ? REQ_A : REQ_B;
                    end
                    mem_req_d  = 1'b1;
                    mem_addr_d = (last_d == REQ_A) ? a_addr : b_addr;
                    state_d    = (last_d == REQ_A) ? StWaitA : StWaitB;
                end
            end
            StWaitA: begin
                if (mem_ack) begin
                    fill_a    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWaitB: begin
                if (mem_ack) begin
                    fill_b    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= REQ_B;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign a_ok     = hit_a;
    assign b_ok     = hit_b;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb: vector table of single misses plus hand-written sequences.
module tb_jt10_adpcm_rom_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] a_addr = '0;
    logic        a_roe_n = 1'b1;
    logic [7:0]  a_data;
    logic        a_ok;
    logic [23:0] b_addr = '0;
    logic        b_roe_n = 1'b1;
    logic [7:0]  b_data;
    logic        b_ok;
    logic [23:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt10_adpcm_rom_arb #(
        .AW (24),
        .DW (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_addr   (a_addr),
        .a_roe_n  (a_roe_n),
        .a_data   (a_data),
        .a_ok     (a_ok),
        .b_addr   (b_addr),
        .b_roe_n  (b_roe_n),
        .b_data   (b_data),
        .b_ok     (b_ok),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_data (mem_data)
    );

    typedef struct {
        bit          is_b;
        logic [23:0] addr;
        logic [7:0]  data;
        int          delay;
        logic [23:0] exp_mem_addr;
        logic        exp_ok;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Expect an outstanding request for exp_addr, ack it after 2 clk with d.
    task automatic serve(input string name, input logic [23:0] exp_addr, input logic [7:0] d);
        check({name, " req"}, {31'd0, mem_req}, 32'd1);
        check({name, " addr"}, {8'd0, mem_addr}, {8'd0, exp_addr});
        tick();
        tick();
        check({name, " req held"}, {31'd0, mem_req}, 32'd1);
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack = 1'b0;
        check({name, " req drop"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 24'h012345, 8'hA5, 3, 24'h012345, 1'b1, 8'hA5};
        vecs[1] = '{1'b1, 24'h800020, 8'h3C, 1, 24'h800020, 1'b1, 8'h3C};
        vecs[2] = '{1'b0, 24'hFFFFFF, 8'h00, 0, 24'hFFFFFF, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 24'h000000, 8'hFF, 2, 24'h000000, 1'b1, 8'hFF};
        vecs[4] = '{1'b0, 24'h000000, 8'h5A, 1, 24'h000000, 1'b1, 8'h5A};

        // Reset state
        #3;
        check("rst a_ok", {31'd0, a_ok}, 32'd0);
        check("rst b_ok", {31'd0, b_ok}, 32'd0);
        check("rst a_data", {24'd0, a_data}, 32'd0);
        check("rst b_data", {24'd0, b_data}, 32'd0);
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_addr", {8'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single misses from the table, one requester at a time
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_b) begin
                b_addr  = vecs[i].addr;
                b_roe_n = 1'b0;
            end else begin
                a_addr  = vecs[i].addr;
                a_roe_n = 1'b0;
            end
            tick();
            check($sformatf("v%0d req", i), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d addr", i), {8'd0, mem_addr}, {8'd0, vecs[i].exp_mem_addr});
            for (int k = 0; k < vecs[i].delay; k++) tick();
            mem_ack  = 1'b1;
            mem_data = vecs[i].data;
            tick();
            mem_ack = 1'b0;
            check($sformatf("v%0d ok", i), {31'd0, vecs[i].is_b ? b_ok : a_ok},
                  {31'd0, vecs[i].exp_ok});
            check($sformatf("v%0d data", i), {24'd0, vecs[i].is_b ? b_data : a_data},
                  {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d req low", i), {31'd0, mem_req}, 32'd0);
            tick();
            check($sformatf("v%0d no rereq", i), {31'd0, mem_req}, 32'd0);
            a_roe_n = 1'b1;
            b_roe_n = 1'b1;
        end

        // Hit with no traffic: a_addr=0 cached as 5A
        a_roe_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("hit req", {31'd0, mem_req}, 32'd0);
            check("hit ok", {31'd0, a_ok}, 32'd1);
        end
        check("hit data", {24'd0, a_data}, 32'h5A);
        a_roe_n = 1'b1;

        // Tie and strict round-robin
        do_reset();
        a_addr = 24'h000010; b_addr = 24'h800020;
        a_roe_n = 1'b0; b_roe_n = 1'b0;
        tick();
        serve("rr0 A", 24'h000010, 8'h10);
        check("rr0 a_ok", {31'd0, a_ok}, 32'd1);
        tick();
        serve("rr1 B", 24'h800020, 8'h20);
        check("rr1 b_ok", {31'd0, b_ok}, 32'd1);
        a_addr = 24'h000011; b_addr = 24'h800021;
        tick();
        serve("rr2 A", 24'h000011, 8'h11);
        a_addr = 24'h000012;
        tick();
        serve("rr3 B", 24'h800021, 8'h21);
        b_addr = 24'h800022;
        tick();
        serve("rr4 A", 24'h000012, 8'h12);
        a_roe_n = 1'b1;
        tick();
        serve("rr5 B", 24'h800022, 8'h22);
        b_roe_n = 1'b1;
        check("rr5 b_data", {24'd0, b_data}, 32'h22);

        // Address change in flight, then roe_n high during WAIT
        a_addr = 24'h000100; a_roe_n = 1'b0;
        tick();
        check("chg req", {31'd0, mem_req}, 32'd1);
        check("chg addr", {8'd0, mem_addr}, 32'h000100);
        a_addr = 24'h000101;
        tick();
        check("chg addr stable", {8'd0, mem_addr}, 32'h000100);
        mem_ack = 1'b1; mem_data = 8'h11;
        tick();
        mem_ack = 1'b0;
        check("chg ok low", {31'd0, a_ok}, 32'd0);
        check("chg data", {24'd0, a_data}, 32'h11);
        tick();
        check("chg rereq", {31'd0, mem_req}, 32'd1);
        check("chg readdr", {8'd0, mem_addr}, 32'h000101);
        a_addr = 24'h000100; a_roe_n = 1'b1;
        #1;
        check("chg old tag", {31'd0, a_ok}, 32'd1);
        tick();
        mem_ack = 1'b1; mem_data = 8'h22;
        tick();
        mem_ack = 1'b0;
        check("roe fill old", {31'd0, a_ok}, 32'd0);
        a_addr = 24'h000101;
        #1;
        check("roe fill ok", {31'd0, a_ok}, 32'd1);
        check("roe fill data", {24'd0, a_data}, 32'h22);

        // Stray ack in IDLE
        mem_ack = 1'b1; mem_data = 8'h77;
        tick();
        mem_ack = 1'b0;
        tick();
        check("stray req", {31'd0, mem_req}, 32'd0);
        check("stray a_data", {24'd0, a_data}, 32'h22);
        check("stray a_ok", {31'd0, a_ok}, 32'd1);
        check("stray b_data", {24'd0, b_data}, 32'h22);

        // Asynchronous reset during WAIT_B
        b_addr = 24'h123456; b_roe_n = 1'b0;
        tick();
        check("wb req", {31'd0, mem_req}, 32'd1);
        check("wb addr", {8'd0, mem_addr}, 32'h123456);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst req", {31'd0, mem_req}, 32'd0);
        check("arst addr", {8'd0, mem_addr}, 32'd0);
        check("arst a_ok", {31'd0, a_ok}, 32'd0);
        check("arst b_ok", {31'd0, b_ok}, 32'd0);
        check("arst a_data", {24'd0, a_data}, 32'd0);
        check("arst b_data", {24'd0, b_data}, 32'd0);
        b_roe_n = 1'b1;
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 8'h99;
        tick();
        mem_ack = 1'b0;
        tick();
        check("late ack req", {31'd0, mem_req}, 32'd0);
        check("late ack b_ok", {31'd0, b_ok}, 32'd0);
        check("late ack b_data", {24'd0, b_data}, 32'd0);

        // Read disabled with an uncached address
        b_addr = 24'h555555; b_roe_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("dis req", {31'd0, mem_req}, 32'd0);
        check("dis b_ok", {31'd0, b_ok}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
